// File: rtl/spectral_pkg.sv
// Shared constants and the saturating gain helper for the spectral mask datapath.
package spectral_pkg;

  // Widest bin index supported (FFT_POINT up to 65536).
  localparam int BIN_W_MAX = 16;

  // Arithmetic left shift by sh, clamped to the signed range of a dw-bit word.
  function automatic logic signed [31:0] sat_shl(input logic signed [31:0] x,
                                                 input logic [1:0]         sh,
                                                 input int unsigned        dw);
    logic signed [35:0] y;
    logic signed [35:0] hi;
    logic signed [35:0] lo;
    y  = 36'(x);
    y  = y <<< sh;
    hi = (36'sd1 <<< (dw - 1)) - 36'sd1;
    lo = -(36'sd1 <<< (dw - 1));
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return 32'(y);
  endfunction

endpackage

// File: rtl/bin_mask_cmp.sv
// Combinational pass/mask decision for one bin against the frame's band bounds.
module bin_mask_cmp
  import spectral_pkg::*;
#(
  parameter int FFT_POINT = 8192,
  parameter int MIRROR    = 1,
  parameter int BW        = $clog2(FFT_POINT)
) (
  input  logic [BW-1:0] bin,
  input  logic [BW-1:0] lo,
  input  logic [BW-1:0] hi,
  output logic          pass
);

  localparam int EW = BIN_W_MAX + 1;

  logic [EW-1:0] b, l, h, mlo, mhi;
  logic          in_main, in_mirror;

  // Mirror bounds need one extra bit: lo=0 maps to FFT_POINT, which no bin reaches.
  always_comb begin
    b         = EW'(bin);
    l         = EW'(lo);
    h         = EW'(hi);
    mlo       = EW'(FFT_POINT) - h;
    mhi       = EW'(FFT_POINT) - l;
    in_main   = (b >= l) && (b <= h);
    in_mirror = (MIRROR != 0) && (b >= mlo) && (b <= mhi);
    pass      = (l <= h) && (in_main || in_mirror);
  end

endmodule

// File: rtl/spectral_mask.sv
// Per-frame band-pass mask with saturating gain between forward FFT and IFFT streams.
module spectral_mask
  import spectral_pkg::*;
#(
  parameter int FFT_POINT = 8192,
  parameter int DW        = 16,
  parameter int MIRROR    = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(FFT_POINT)-1:0] cfg_lo_bin,
  input  logic [$clog2(FFT_POINT)-1:0] cfg_hi_bin,
  input  logic [1:0]                   cfg_shift,
  input  logic [2*DW-1:0]              s_tdata,
  input  logic                         s_tvalid,
  input  logic                         s_tlast,
  output logic                         s_tready,
  output logic [2*DW-1:0]              m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [15:0]                  frame_cnt,
  output logic                         err_last_early,
  output logic                         err_last_missing
);

  localparam int BW = $clog2(FFT_POINT);
  localparam logic [BW-1:0] LAST_BIN = BW'(FFT_POINT - 1);

  logic [BW-1:0]   bin_q, bin_d;
  logic [BW-1:0]   lo_q, lo_d, hi_q, hi_d;
  logic [1:0]      sh_q, sh_d;
  logic [2*DW-1:0] data_q, data_d;
  logic            vld_q, vld_d, last_q, last_d;
  logic [15:0]     fcnt_q, fcnt_d;
  logic            early_q, early_d, miss_q, miss_d;

  logic            in_hs, at_first, at_last, pass;
  logic [BW-1:0]   eff_lo, eff_hi;
  logic [1:0]      eff_sh;
  logic [DW-1:0]   re_out, im_out;

  assign s_tready = !vld_q || m_tready;
  assign in_hs    = s_tvalid && s_tready;
  assign at_first = (bin_q == '0);
  assign at_last  = (bin_q == LAST_BIN);

  // Bin 0 uses the live config (it is being captured now); later bins use the shadow.
  assign eff_lo = at_first ? cfg_lo_bin : lo_q;
  assign eff_hi = at_first ? cfg_hi_bin : hi_q;
  assign eff_sh = at_first ? cfg_shift  : sh_q;

  bin_mask_cmp #(.FFT_POINT(FFT_POINT), .MIRROR(MIRROR), .BW(BW)) u_cmp (
    .bin  (bin_q),
    .lo   (eff_lo),
    .hi   (eff_hi),
    .pass (pass)
  );

  always_comb begin
    re_out = DW'(sat_shl(32'(signed'(s_tdata[DW-1:0])), eff_sh, DW));
    im_out = DW'(sat_shl(32'(signed'(s_tdata[2*DW-1:DW])), eff_sh, DW));
  end

  always_comb begin
    bin_d   = bin_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    sh_d    = sh_q;
    data_d  = data_q;
    vld_d   = vld_q;
    last_d  = last_q;
    fcnt_d  = fcnt_q;
    early_d = 1'b0;
    miss_d  = 1'b0;

    if (vld_q && m_tready && last_q) fcnt_d = fcnt_q + 16'd1;
    if (s_tready) vld_d = s_tvalid;

    if (in_hs) begin
      if (at_first) begin
        lo_d = cfg_lo_bin;
        hi_d = cfg_hi_bin;
        sh_d = cfg_shift;
      end
      data_d  = pass ? {im_out, re_out} : '0;
      // Early s_tlast closes the frame here so the IFFT sees a bounded frame.
      last_d  = at_last || s_tlast;
      early_d = s_tlast && !at_last;
      miss_d  = at_last && !s_tlast;
      bin_d   = (at_last || s_tlast) ? '0 : bin_q + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      fcnt_q  <= '0;
      early_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      bin_q   <= bin_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      fcnt_q  <= fcnt_d;
      early_q <= early_d;
      miss_q  <= miss_d;
    end
  end

  assign m_tdata          = data_q;
  assign m_tvalid         = vld_q;
  assign m_tlast          = last_q;
  assign frame_cnt        = fcnt_q;
  assign err_last_early   = early_q;
  assign err_last_missing = miss_q;

endmodule
